// File: rtl/fetch_seq_if.sv
// fetch_seq_if: bundle between the fetch sequencer, the ROM and decode.
// Ports: ROM bus (cycle, addr, nibble_in), decode handoff
// (instr_valid, opr, opa, word2, two_byte), redirect (jmp_valid,
// jmp_addr, jmp_ack); FETCH_HOLD_EN adds hold.
// master = sequencer side, slave = ROM/decode/execute side.
interface fetch_seq_if;
   logic [2:0]  cycle;
   logic [11:0] addr;
   logic [3:0]  nibble_in;
   logic        instr_valid;
   logic [3:0]  opr;
   logic [3:0]  opa;
   logic [7:0]  word2;
   logic        two_byte;
   logic        jmp_valid;
   logic [11:0] jmp_addr;
   logic        jmp_ack;
`ifdef FETCH_HOLD_EN
   logic        hold;

   modport master (
      output cycle, addr, instr_valid,
      output opr, opa, word2, two_byte, jmp_ack,
      input  nibble_in, jmp_valid, jmp_addr, hold
   );
   modport slave (
      input  cycle, addr, instr_valid,
      input  opr, opa, word2, two_byte, jmp_ack,
      output nibble_in, jmp_valid, jmp_addr, hold
   );
`else
   modport master (
      output cycle, addr, instr_valid,
      output opr, opa, word2, two_byte, jmp_ack,
      input  nibble_in, jmp_valid, jmp_addr
   );
   modport slave (
      input  cycle, addr, instr_valid,
      input  opr, opa, word2, two_byte, jmp_ack,
      output nibble_in, jmp_valid, jmp_addr
   );
`endif
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: 4004-style instruction fetch sequencer. Runs the 8-phase
// machine cycle, drives the 12-bit ROM address, captures nibbles at
// M1/M2 and delivers 1- or 2-byte instructions with a valid pulse.
// Ports: clk, rst_n (sync, active low), bus (fetch_seq_if.master).
// Optional macro FETCH_HOLD_EN adds bus.hold to stall at X3.
module fetch_seq #(
   parameter logic [11:0] RESET_PC = 12'h000
) (
   input logic         clk,
   input logic         rst_n,
   fetch_seq_if.master bus
);
   typedef enum logic {FETCH1, FETCH2} state_t;

   state_t      state;
   logic [2:0]  cyc;
   logic [11:0] pc;
   logic [3:0]  sh_hi;
   logic [3:0]  sh_lo;
   logic [7:0]  sh_first;
   logic        sh_two;
   logic [3:0]  opr_q;
   logic [3:0]  opa_q;
   logic [7:0]  word2_q;
   logic        two_q;
   logic        valid_q;
   logic        ack_q;
   logic        x3;
   logic        stall;

   assign x3 = (cyc == 3'd7);

`ifdef FETCH_HOLD_EN
   assign stall = x3 & bus.hold;
`else
   assign stall = 1'b0;
`endif

   // JCN, JUN, JMS, ISZ and FIM (even lo) carry a second byte.
   function automatic logic is_two(
      input logic [3:0] hi,
      input logic [3:0] lo
   );
      logic r;
      r = 1'b0;
      unique case (1'b1)
         (hi == 4'h2): r = ~lo[0];
         (hi == 4'h1),
         (hi == 4'h4),
         (hi == 4'h5),
         (hi == 4'h7): r = 1'b1;
         default:      r = 1'b0;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= FETCH1;
         cyc      <= 3'd0;
         pc       <= RESET_PC;
         sh_hi    <= 4'h0;
         sh_lo    <= 4'h0;
         sh_first <= 8'h00;
         sh_two   <= 1'b0;
         opr_q    <= 4'h0;
         opa_q    <= 4'h0;
         word2_q  <= 8'h00;
         two_q    <= 1'b0;
         valid_q  <= 1'b0;
         ack_q    <= 1'b0;
      end else if (!stall) begin
         cyc     <= cyc + 3'd1;
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         if (cyc == 3'd3)
            sh_hi <= bus.nibble_in;
         if (cyc == 3'd4) begin
            sh_lo <= bus.nibble_in;
            if (state == FETCH1)
               sh_two <= is_two(sh_hi, bus.nibble_in);
         end
         if (x3) begin
            pc <= pc + 12'd1;
            if (state == FETCH2) begin
               {opr_q, opa_q} <= sh_first;
               word2_q        <= {sh_hi, sh_lo};
               two_q          <= 1'b1;
               valid_q        <= 1'b1;
               state          <= FETCH1;
            end else if (!sh_two) begin
               {opr_q, opa_q} <= {sh_hi, sh_lo};
               word2_q        <= 8'h00;
               two_q          <= 1'b0;
               valid_q        <= 1'b1;
            end else if (!bus.jmp_valid) begin
               // a redirect drops a half-fetched 2-byte op
               sh_first <= {sh_hi, sh_lo};
               state    <= FETCH2;
            end
            if (bus.jmp_valid) begin
               pc    <= bus.jmp_addr;
               state <= FETCH1;
               ack_q <= 1'b1;
            end
         end
      end
   end

   assign bus.cycle       = cyc;
   assign bus.addr        = pc;
   assign bus.instr_valid = valid_q;
   assign bus.opr         = opr_q;
   assign bus.opa         = opa_q;
   assign bus.word2       = word2_q;
   assign bus.two_byte    = two_q;
   assign bus.jmp_ack     = ack_q;
endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
CPU-side instruction fetch sequencer for the 4004-style core. It generates the 8-phase machine-cycle code (A1..X3) and the 12-bit fetch address consumed by the program ROM, and captures the instruction nibbles the ROM drives at M1/M2. It assembles single- and two-byte instructions, then hands them to decode/execute with a one-clock valid pulse. It also accepts jump redirects from execute.

Parameters:
RESET_PC, 12'h000, program counter value after reset

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
cycle  output  3  machine-cycle phase: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7
addr  output  12  fetch address to ROM, equal to PC, stable for all 8 phases
nibble_in  input  4  ROM data nibble; valid only at cycle 3 (upper) and 4 (lower)
instr_valid  output  1  one-clock pulse: opr/opa/word2/two_byte updated
opr  output  4  first-byte upper nibble
opa  output  4  first-byte lower nibble
word2  output  8  second byte of two-byte instruction, 0 for single-byte
two_byte  output  1  delivered instruction is two-byte
jmp_valid  input  1  redirect request from execute; level, held until jmp_ack
jmp_addr  input  12  redirect target
jmp_ack  output  1  one-clock pulse: redirect taken

Behaviour:
- Reset (rst_n low at edge): cycle=0, PC=RESET_PC, state=FETCH1, opr=opa=0, word2=0, two_byte=0, instr_valid=0, jmp_ack=0, all shadow registers 0. Reset mid-cycle aborts any fetch; no valid pulse.
- cycle increments by 1 every clock, 7 wraps to 0 (the "X3 edge" is the clock at which cycle==7).
- Samples nibble_in at the edge where cycle==3 into shadow high and cycle==4 into shadow low. Samples at no other phase. A Z/X value at other phases is ignored.
- States: FETCH1 (first byte), FETCH2 (second byte).
- FETCH1, cycle==4 edge: decode the byte {hi,lo}. It is two-byte when hi is 1 (JCN), 4 (JUN), 5 (JMS), or 7 (ISZ), or when hi is 2 and lo[0]=0 (FIM). All other bytes are single-byte.
- FETCH1, X3 edge, single-byte: opr/opa <= shadow, word2 <= 0, two_byte <= 0, instr_valid pulses high for the next clock (cycle==0). PC <= PC+1.
- FETCH1, X3 edge, two-byte: hold first byte in shadow, PC <= PC+1, state <= FETCH2, no pulse.
- FETCH2, X3 edge: opr/opa <= first byte, word2 <= second byte, two_byte <= 1, instr_valid pulses, PC <= PC+1, state <= FETCH1.
- Output registers hold their values between pulses. Latency is 8 clocks from the start of the A1 phase for single-byte and 16 clocks for two-byte.
- PC arithmetic is 12-bit modulo. 12'hFFF+1 = 12'h000, with no flag.
- Redirect: jmp_valid is evaluated only at the X3 edge and ignored otherwise.
  - When taken: PC <= jmp_addr (overrides increment), state <= FETCH1, jmp_ack pulses for the next clock.
  - If the same edge completes an instruction (single-byte or FETCH2), that instruction is still delivered with instr_valid.
  - If the same edge would enter FETCH2, the partial first byte is discarded and no pulse is issued.
- addr changes only at X3 edges (or reset).

Optional Feature:
FETCH_HOLD_EN: when defined, adds port hold (input, 1) to stall the fetch.
- hold sampled high at an X3 edge freezes everything: cycle stays 7, PC/state/outputs unchanged, no instr_valid or jmp_ack.
- When hold is released, the next edge performs the normal X3 actions.
- hold at phases other than 7 is ignored.
- Without the macro, the port is absent and the sequencer free-runs.

Test Plan:
- Reset, ROM 000:00 001:85 002:97 -> pulses at clocks 8/16/24 with opr/opa 0/0, 8/5, 9/7; two_byte=0; addr 000→001→002→003.
- ROM 000:40 001:12 002:00 -> one pulse at clock 16 with opr=4, opa=0, word2=8'h12, two_byte=1; next pulse at clock 24 with opr=0.
- RESET_PC=12'hFFF, ROM FFF:00 -> pulse, then addr=12'h000 from clock 8.
- jmp_valid=1 with jmp_addr=12'h3A5 raised at clock 2 while fetching a single-byte -> taken at the X3 edge; jmp_ack at clock 8, instr_valid at clock 8, addr=12'h3A5. Repeat during FETCH1 of 0x40 -> no instr_valid, addr=12'h3A5.
- rst_n low at cycle 4 of a 0x40 fetch -> all outputs 0, cycle=0, addr=RESET_PC; no stale pulse afterwards.
- (FETCH_HOLD_EN) hold=1 for 5 clocks from cycle 7 -> cycle stays 7 and addr is unchanged; pulse occurs on the first edge after release.
